// File: rtl/lcd_spi_write.sv
// ---------------------------------------------------------------------------
// lcd_spi_write
//
// Byte-level 4-wire SPI writer for the 240x320 TFT panel. Accepts a 9-bit
// word (bit 8 = D/C, bits 7:0 = payload) whenever en_write is seen high while
// idle. It shifts the payload out MSB-first in SPI mode 0 and returns a
// one-cycle wr_done pulse when the byte is complete.
//
// Handshake: en_write is a level request, sampled only in IDLE. Each sample
// taken high starts exactly one byte. data is captured one cycle after that
// sample, so upstream data registers may lag their enable by one cycle.
// wr_done pulses for one cycle per byte, on the cycle where CS rises. A
// started byte always completes. Only reset can abandon it.
//
// Parameters:
//   CLK_DIV     sys_clk cycles per SCLK half-period (1..255)
//   GAP_CYCLES  idle cycles after each byte before en_write is re-sampled (2..15)
//
// Ports:
//   sys_clk    in   clock, rising edge
//   sys_rst_n  in   asynchronous active-low reset
//   en_write   in   level request
//   data[8:0]  in   {D/C, byte}
//   wr_done    out  one-cycle pulse at byte completion
//   lcd_sclk   out  SPI clock, idles low
//   lcd_mosi   out  serial data
//   lcd_dc     out  D/C line, held until the next byte is latched
//   lcd_cs_n   out  chip select, active low
//   dbg_state  out  current FSM state (IDLE=0 LATCH=1 SHIFT=2 DONE=3 GAP=4)
// ---------------------------------------------------------------------------
module lcd_spi_write #(
  parameter int CLK_DIV    = 2,
  parameter int GAP_CYCLES = 2
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       en_write,
  input  logic [8:0] data,
  output logic       wr_done,
  output logic       lcd_sclk,
  output logic       lcd_mosi,
  output logic       lcd_dc,
  output logic       lcd_cs_n,
  output logic [2:0] dbg_state
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LATCH = 3'd1,
    ST_SHIFT = 3'd2,
    ST_DONE  = 3'd3,
    ST_GAP   = 3'd4
  } state_t;

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [3:0] GAP_LAST = 4'(GAP_CYCLES - 1);

  state_t     state;
  logic [6:0] shift_reg;   // bits still to send after the one on lcd_mosi
  logic [2:0] bit_cnt;     // falling SCLK edges seen so far in this byte
  logic [7:0] div_cnt;
  logic [3:0] gap_cnt;

  assign dbg_state = state;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state     <= ST_IDLE;
      shift_reg <= '0;
      bit_cnt   <= '0;
      div_cnt   <= '0;
      gap_cnt   <= '0;
      wr_done   <= 1'b0;
      lcd_sclk  <= 1'b0;
      lcd_mosi  <= 1'b0;
      lcd_dc    <= 1'b0;
      lcd_cs_n  <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          lcd_cs_n <= 1'b1;
          lcd_sclk <= 1'b0;
          wr_done  <= 1'b0;
          if (en_write) state <= ST_LATCH;
        end

        // Data is captured on exit, one cycle after the enable was seen.
        ST_LATCH: begin
          shift_reg <= data[6:0];
          lcd_mosi  <= data[7];
          lcd_dc    <= data[8];
          lcd_cs_n  <= 1'b0;
          bit_cnt   <= '0;
          div_cnt   <= '0;
          state     <= ST_SHIFT;
        end

        ST_SHIFT: begin
          if (div_cnt == DIV_LAST) begin
            div_cnt  <= '0;
            lcd_sclk <= ~lcd_sclk;
            // lcd_sclk currently high means this toggle is a falling edge.
            // MOSI only changes here, so it is stable around each rising edge.
            if (lcd_sclk) begin
              if (bit_cnt == 3'd7) begin
                lcd_cs_n <= 1'b1;
                lcd_mosi <= 1'b0;
                wr_done  <= 1'b1;
                state    <= ST_DONE;
              end else begin
                lcd_mosi  <= shift_reg[6];
                shift_reg <= {shift_reg[5:0], 1'b0};
                bit_cnt   <= bit_cnt + 3'd1;
              end
            end
          end else begin
            div_cnt <= div_cnt + 8'd1;
          end
        end

        ST_DONE: begin
          wr_done <= 1'b0;
          gap_cnt <= '0;
          state   <= ST_GAP;
        end

        // The gap keeps an upstream stage that drops en_write shortly after
        // wr_done from triggering a spurious extra byte.
        ST_GAP: begin
          if (gap_cnt == GAP_LAST) begin
            state <= ST_IDLE;
          end else begin
            gap_cnt <= gap_cnt + 4'd1;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_spi_write.sv
// ---------------------------------------------------------------------------
// tb_lcd_spi_write
//
// Three instances share the clock, the reset and data: CLK_DIV = 2 (default),
// 1 and 5. Each instance has its own en_write. An SPI monitor per instance
// rebuilds bytes from SCLK/MOSI/CS and records wr_done timing. Scenario tasks
// compare the recorded values against expectations derived from the byte
// format and the timing rules. Those rules are: latency 1+16*D, period
// 16*D+GAP+3, and an SCLK half-period of D.
// ---------------------------------------------------------------------------
module tb_lcd_spi_write;

  localparam int GAP = 2;

  logic       sys_clk   = 1'b0;
  logic       sys_rst_n = 1'b1;
  logic [2:0] en        = '0;
  logic [8:0] data      = '0;
  logic [2:0] wr_done, sclk, mosi, dc, cs_n;
  logic [2:0] st0, st1, st2;

  int chk = 0;
  int err = 0;
  int cyc = 0;

  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) cyc <= cyc + 1;

  lcd_spi_write #(.CLK_DIV(2), .GAP_CYCLES(GAP)) u_dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .en_write(en[0]), .data(data),
    .wr_done(wr_done[0]), .lcd_sclk(sclk[0]), .lcd_mosi(mosi[0]),
    .lcd_dc(dc[0]), .lcd_cs_n(cs_n[0]), .dbg_state(st0));

  lcd_spi_write #(.CLK_DIV(1), .GAP_CYCLES(GAP)) u_div1 (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .en_write(en[1]), .data(data),
    .wr_done(wr_done[1]), .lcd_sclk(sclk[1]), .lcd_mosi(mosi[1]),
    .lcd_dc(dc[1]), .lcd_cs_n(cs_n[1]), .dbg_state(st1));

  lcd_spi_write #(.CLK_DIV(5), .GAP_CYCLES(GAP)) u_div5 (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .en_write(en[2]), .data(data),
    .wr_done(wr_done[2]), .lcd_sclk(sclk[2]), .lcd_mosi(mosi[2]),
    .lcd_dc(dc[2]), .lcd_cs_n(cs_n[2]), .dbg_state(st2));

  function automatic int div_of(input int i);
    return (i == 0) ? 2 : (i == 1) ? 1 : 5;
  endfunction

  // ---------------- SPI monitor ----------------
  logic [2:0] prev_sclk = '0;
  logic [2:0] prev_cs   = 3'b111;
  logic [2:0] prev_wd   = '0;
  logic [2:0] in_byte   = '0;
  logic [7:0] shift_cap [3];
  int         rises     [3];
  int         last_tg   [3];
  int         hp_bad    [3];
  int         byte_cnt  [3];
  logic [8:0] cap_mem   [3][16];
  int         cap_rises [3][16];
  int         wd_cnt    [3];
  int         wd_cyc    [3][16];
  int         wd_long   [3];

  initial begin
    for (int i = 0; i < 3; i++) begin
      shift_cap[i] = '0; rises[i] = 0; last_tg[i] = 0; hp_bad[i] = 0;
      byte_cnt[i] = 0; wd_cnt[i] = 0; wd_long[i] = 0;
    end
  end

  always @(negedge sys_clk) begin
    for (int i = 0; i < 3; i++) begin
      logic [7:0] cap_v;
      int         rise_v;
      int         tg_v;
      logic       inb_v;
      cap_v  = shift_cap[i];
      rise_v = rises[i];
      tg_v   = last_tg[i];
      inb_v  = in_byte[i];
      if (!sys_rst_n) begin
        inb_v  = 1'b0;
        rise_v = 0;
      end else begin
        if (prev_cs[i] && !cs_n[i]) begin
          inb_v  = 1'b1;
          cap_v  = '0;
          rise_v = 0;
          tg_v   = cyc;
        end
        if (sclk[i] !== prev_sclk[i]) begin
          if (cyc - tg_v != div_of(i)) hp_bad[i] <= hp_bad[i] + 1;
          tg_v = cyc;
          if (sclk[i] && !cs_n[i]) begin
            rise_v = rise_v + 1;
            cap_v  = {cap_v[6:0], mosi[i]};
          end
        end
        if (!prev_cs[i] && cs_n[i] && inb_v) begin
          cap_mem[i][byte_cnt[i] % 16]   <= {dc[i], cap_v};
          cap_rises[i][byte_cnt[i] % 16] <= rise_v;
          byte_cnt[i] <= byte_cnt[i] + 1;
          inb_v = 1'b0;
        end
        if (wr_done[i]) begin
          if (prev_wd[i]) wd_long[i] <= wd_long[i] + 1;
          else begin
            wd_cyc[i][wd_cnt[i] % 16] <= cyc;
            wd_cnt[i] <= wd_cnt[i] + 1;
          end
        end
      end
      shift_cap[i] <= cap_v;
      rises[i]     <= rise_v;
      last_tg[i]   <= tg_v;
      in_byte[i]   <= inb_v;
      prev_sclk[i] <= sclk[i];
      prev_cs[i]   <= cs_n[i];
      prev_wd[i]   <= wr_done[i];
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(negedge sys_clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int t = 0; t < n; t++) step();
  endtask

  // One-cycle en_write pulse; k is the posedge that samples it.
  task automatic pulse_en(input int i, input logic [8:0] v, input int width, output int k);
    data  = v;
    en[i] = 1'b1;
    k     = cyc + 1;
    steps(width);
    en[i] = 1'b0;
  endtask

  task automatic wait_wd(input int i, input int start, input int budget, output bit ok);
    ok = 1'b0;
    for (int t = 0; t < budget; t++) begin
      step();
      if (wd_cnt[i] != start) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    int bad;
    #1 sys_rst_n = 1'b0;
    en   = '0;
    data = '0;
    steps(3);
    chk++; if (cs_n !== 3'b111) begin err++; $display("FAIL reset_cs_n: got %b expected 111", cs_n); end
    chk++; if (sclk !== 3'b000) begin err++; $display("FAIL reset_sclk: got %b expected 000", sclk); end
    chk++; if (mosi !== 3'b000) begin err++; $display("FAIL reset_mosi: got %b expected 000", mosi); end
    chk++; if (dc !== 3'b000) begin err++; $display("FAIL reset_dc: got %b expected 000", dc); end
    chk++; if (wr_done !== 3'b000) begin err++; $display("FAIL reset_wr_done: got %b expected 000", wr_done); end
    sys_rst_n = 1'b1;
    bad = 0;
    for (int t = 0; t < 100; t++) begin
      step();
      if (cs_n !== 3'b111 || sclk !== 3'b000 || mosi !== 3'b000 ||
          dc !== 3'b000 || wr_done !== 3'b000) bad++;
    end
    chk++; if (bad != 0) begin err++; $display("FAIL reset_idle_hold: got %0d changed cycles expected 0", bad); end
  endtask

  task automatic test_command();
    int k, bc, wc, hb, wl;
    bit ok;
    bc = byte_cnt[0]; wc = wd_cnt[0]; hb = hp_bad[0]; wl = wd_long[0];
    pulse_en(0, 9'h02C, 1, k);
    wait_wd(0, wc, 200, ok);
    chk++; if (!ok) begin err++; $display("FAIL cmd_wr_done_timeout: got none expected pulse"); end
    step();
    chk++; if (wd_cyc[0][wc % 16] - k != 33) begin err++; $display("FAIL cmd_latency: got %0d expected 33", wd_cyc[0][wc % 16] - k); end
    chk++; if (byte_cnt[0] != bc + 1) begin err++; $display("FAIL cmd_byte_count: got %0d expected %0d", byte_cnt[0] - bc, 1); end
    chk++; if (cap_mem[0][bc % 16] !== 9'h02C) begin err++; $display("FAIL cmd_byte: got %h expected 02c", cap_mem[0][bc % 16]); end
    chk++; if (cap_rises[0][bc % 16] != 8) begin err++; $display("FAIL cmd_rises: got %0d expected 8", cap_rises[0][bc % 16]); end
    chk++; if (hp_bad[0] != hb) begin err++; $display("FAIL cmd_half_period: got %0d bad expected 0", hp_bad[0] - hb); end
    chk++; if (wd_long[0] != wl) begin err++; $display("FAIL cmd_wr_done_width: got %0d long expected 0", wd_long[0] - wl); end
    steps(10);
  endtask

  task automatic test_lagging();
    int k, bc, wc;
    bit ok;
    bc = byte_cnt[0]; wc = wd_cnt[0];
    data  = 9'h000;
    en[0] = 1'b1;
    k     = cyc + 1;
    step();
    data  = 9'h1A5;
    en[0] = 1'b0;
    wait_wd(0, wc, 200, ok);
    chk++; if (!ok) begin err++; $display("FAIL lag_wr_done_timeout: got none expected pulse"); end
    step();
    chk++; if (cap_mem[0][bc % 16] !== 9'h1A5) begin err++; $display("FAIL lag_byte: got %h expected 1a5", cap_mem[0][bc % 16]); end
    chk++; if (dc[0] !== 1'b1) begin err++; $display("FAIL lag_dc_hold: got %b expected 1", dc[0]); end
    steps(10);
  endtask

  task automatic test_back_to_back();
    logic [8:0] vals [3];
    int w [3];
    int k, bc, wc;
    bit ok;
    vals[0] = 9'h1F8; vals[1] = 9'h100; vals[2] = 9'h1FF;
    bc = byte_cnt[0]; wc = wd_cnt[0];
    data  = vals[0];
    en[0] = 1'b1;
    k     = cyc + 1;
    for (int j = 0; j < 3; j++) begin
      wait_wd(0, wc + j, 200, ok);
      chk++; if (!ok) begin err++; $display("FAIL stream_wr_done_timeout: got none expected pulse %0d", j); end
      w[j] = wd_cyc[0][(wc + j) % 16];
      steps(2);
      if (j < 2) data = vals[j + 1];
      else en[0] = 1'b0;
    end
    steps(100);
    chk++; if (w[0] - k != 33) begin err++; $display("FAIL stream_first_latency: got %0d expected 33", w[0] - k); end
    chk++; if (w[1] - w[0] != 37) begin err++; $display("FAIL stream_period_1: got %0d expected 37", w[1] - w[0]); end
    chk++; if (w[2] - w[1] != 37) begin err++; $display("FAIL stream_period_2: got %0d expected 37", w[2] - w[1]); end
    chk++; if (byte_cnt[0] != bc + 3) begin err++; $display("FAIL stream_byte_count: got %0d expected 3", byte_cnt[0] - bc); end
    for (int j = 0; j < 3; j++) begin
      chk++; if (cap_mem[0][(bc + j) % 16] !== vals[j]) begin err++; $display("FAIL stream_byte_%0d: got %h expected %h", j, cap_mem[0][(bc + j) % 16], vals[j]); end
    end
  endtask

  task automatic test_divider();
    for (int i = 1; i < 3; i++) begin
      int k, bc, wc, hb;
      bit ok;
      logic [8:0] v;
      v  = 9'($urandom_range(0, 511));
      bc = byte_cnt[i]; wc = wd_cnt[i]; hb = hp_bad[i];
      pulse_en(i, v, 1, k);
      wait_wd(i, wc, 300, ok);
      chk++; if (!ok) begin err++; $display("FAIL div%0d_timeout: got none expected pulse", div_of(i)); end
      step();
      chk++; if (wd_cyc[i][wc % 16] - k != 1 + 16 * div_of(i)) begin err++; $display("FAIL div%0d_latency: got %0d expected %0d", div_of(i), wd_cyc[i][wc % 16] - k, 1 + 16 * div_of(i)); end
      chk++; if (hp_bad[i] != hb) begin err++; $display("FAIL div%0d_half_period: got %0d bad expected 0", div_of(i), hp_bad[i] - hb); end
      chk++; if (cap_mem[i][bc % 16] !== v) begin err++; $display("FAIL div%0d_byte: got %h expected %h", div_of(i), cap_mem[i][bc % 16], v); end
      chk++; if (cap_rises[i][bc % 16] != 8) begin err++; $display("FAIL div%0d_rises: got %0d expected 8", div_of(i), cap_rises[i][bc % 16]); end
      steps(10);
    end
  endtask

  task automatic test_abort();
    int k, bc, wc;
    bit ok;
    bc = byte_cnt[0];
    pulse_en(0, 9'h1C3, 1, k);
    ok = 1'b0;
    for (int t = 0; t < 100; t++) begin
      if (rises[0] >= 4) begin ok = 1'b1; break; end
      step();
    end
    chk++; if (!ok) begin err++; $display("FAIL abort_reach_rise4: got %0d rises expected 4", rises[0]); end
    #2 sys_rst_n = 1'b0;
    #1;
    chk++; if (cs_n[0] !== 1'b1) begin err++; $display("FAIL abort_cs_async: got %b expected 1", cs_n[0]); end
    chk++; if (sclk[0] !== 1'b0) begin err++; $display("FAIL abort_sclk: got %b expected 0", sclk[0]); end
    chk++; if (mosi[0] !== 1'b0 || dc[0] !== 1'b0 || wr_done[0] !== 1'b0) begin err++; $display("FAIL abort_outputs: got mosi %b dc %b wr_done %b expected 0 0 0", mosi[0], dc[0], wr_done[0]); end
    steps(3);
    sys_rst_n = 1'b1;
    steps(40);
    chk++; if (byte_cnt[0] != bc) begin err++; $display("FAIL abort_resumed: got %0d bytes expected 0", byte_cnt[0] - bc); end
    wc = wd_cnt[0];
    pulse_en(0, 9'h155, 1, k);
    wait_wd(0, wc, 200, ok);
    chk++; if (!ok) begin err++; $display("FAIL abort_next_timeout: got none expected pulse"); end
    step();
    chk++; if (wd_cyc[0][wc % 16] - k != 33) begin err++; $display("FAIL abort_next_latency: got %0d expected 33", wd_cyc[0][wc % 16] - k); end
    chk++; if (cap_mem[0][bc % 16] !== 9'h155) begin err++; $display("FAIL abort_next_byte: got %h expected 155", cap_mem[0][bc % 16]); end
    chk++; if (cap_rises[0][bc % 16] != 8) begin err++; $display("FAIL abort_next_rises: got %0d expected 8", cap_rises[0][bc % 16]); end
    steps(10);
  endtask

  task automatic test_random();
    logic [8:0] exp_q [$];
    logic [8:0] exp_v;
    for (int n = 0; n < 20; n++) begin
      int k, bc, wc;
      bit ok;
      logic [8:0] v;
      v = 9'($urandom_range(0, 511));
      exp_q.push_back(v);
      steps($urandom_range(0, 5));
      bc = byte_cnt[0]; wc = wd_cnt[0];
      pulse_en(0, v, $urandom_range(1, 3), k);
      wait_wd(0, wc, 200, ok);
      chk++; if (!ok) begin err++; $display("FAIL rand_timeout: got none expected pulse %0d", n); end
      step();
      exp_v = exp_q.pop_front();
      chk++; if (wd_cyc[0][wc % 16] - k != 33) begin err++; $display("FAIL rand_latency: got %0d expected 33", wd_cyc[0][wc % 16] - k); end
      chk++; if (cap_mem[0][bc % 16] !== exp_v) begin err++; $display("FAIL rand_byte: got %h expected %h", cap_mem[0][bc % 16], exp_v); end
      steps(GAP + 2);
    end
  endtask

  initial begin
    test_reset();
    test_command();
    test_lagging();
    test_back_to_back();
    test_divider();
    test_abort();
    test_random();
    $display("CHECKS %0d ERRORS %0d", chk, err);
    $finish;
  end

endmodule
